// File: rtl/spi_adc_pkg.sv
// Shared types and default sizing for the multi-channel SPI A2D model.
package spi_adc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SKIP_1st,
    ACTIVE
  } state_t;

  localparam int NUM_CH_DEF  = 8;
  localparam int DATA_W_DEF  = 12;
  localparam int FRAME_W_DEF = 16;
  localparam int CH_LSB_DEF  = 11;

endpackage

// File: rtl/spi_adc_mch_model_sclk_edge_sync.sv
// Brings the asynchronous SCLK into the clk domain and flags its edges.
module sclk_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  output logic rise,
  output logic fall
);

  logic [2:0] sync;

  // Reset high to match the idle level of SCLK, so no false edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 3'b111;
    end else begin
      sync <= {sync[1:0], sclk};
    end
  end

  assign rise = sync[1] & ~sync[2];
  assign fall = ~sync[1] & sync[2];

endmodule

// File: rtl/spi_adc_mch_model.sv
// SPI slave model of a multi-channel A2D: returns the channel requested in the
// previous frame while capturing the next command.
module spi_adc_mch_model
  import spi_adc_pkg::*;
#(
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int CH_LSB  = CH_LSB_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       SS_n,
  input  logic                       SCLK,
  input  logic                       MOSI,
  input  logic [NUM_CH*DATA_W-1:0]   ch_data,
  output logic                       MISO,
  output logic [FRAME_W-1:0]         cmd,
  output logic [$clog2(NUM_CH)-1:0]  chnl,
  output logic                       rdy,
  output logic                       frame_err
);

  localparam int CHW = $clog2(NUM_CH);
  localparam int CW  = $clog2(FRAME_W + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_W);
  localparam logic [CW-1:0] CNT_MAX  = CW'(FRAME_W + 1);

  state_t             state;
  logic [FRAME_W-1:0] tx;
  logic [FRAME_W-1:0] rx;
  logic [CW-1:0]      cnt;
  logic [DATA_W-1:0]  sel_data;
  logic               sclk_rise;
  logic               sclk_fall;

  sclk_edge_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .sclk  (SCLK),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  assign sel_data = ch_data[chnl*DATA_W +: DATA_W];

  // The first SCLK fall only starts the master's first bit; the MSB is
  // already on MISO, so shifting starts from the second fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rdy       <= 1'b0;
      frame_err <= 1'b0;
      cmd       <= '0;
      chnl      <= '0;
      tx        <= '0;
      rx        <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!SS_n) begin
            state     <= SKIP_1st;
            rdy       <= 1'b0;
            frame_err <= 1'b0;
            cnt       <= '0;
            tx        <= {{(FRAME_W-DATA_W){1'b0}}, sel_data};
          end
        end
        SKIP_1st, ACTIVE: begin
          if (SS_n) begin
            state <= IDLE;
            if (cnt == CNT_FULL) begin
              rdy  <= 1'b1;
              cmd  <= rx;
              chnl <= rx[CH_LSB +: CHW];
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            if (sclk_rise) begin
              rx <= {rx[FRAME_W-2:0], MOSI};
              if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
            end
            if (sclk_fall) begin
              if (state == SKIP_1st) state <= ACTIVE;
              else                   tx    <= {tx[FRAME_W-2:0], 1'b0};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign MISO = SS_n ? 1'bz : tx[FRAME_W-1];

endmodule

// File: tb/tb_spi_adc_mch_model.sv
// Self-checking bench: SPI master driving frames of varying length against a
// frame-level model of the one-frame channel pipeline.
module tb_spi_adc_mch_model;

  localparam int NCH  = 8;
  localparam int DW   = 12;
  localparam int FW   = 16;
  localparam int CHL  = 11;
  localparam int HALF = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              SS_n;
  logic              SCLK;
  logic              MOSI;
  logic [NCH*DW-1:0] ch_data;
  logic              MISO;
  logic [FW-1:0]     cmd;
  logic [2:0]        chnl;
  logic              rdy;
  logic              frame_err;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] chv [NCH];
  logic [FW-1:0] exp_cmd;
  logic [2:0]    exp_chnl;
  int            chg_bit = -1;
  logic [DW-1:0] chg_val;
  logic [31:0]   mw;

  spi_adc_mch_model dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .SS_n      (SS_n),
    .SCLK      (SCLK),
    .MOSI      (MOSI),
    .ch_data   (ch_data),
    .MISO      (MISO),
    .cmd       (cmd),
    .chnl      (chnl),
    .rdy       (rdy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pushChData();
    for (int i = 0; i < NCH; i++) ch_data[i*DW +: DW] = chv[i];
  endtask

  // One SS_n-framed transfer of nbits; the model predicts MISO from the data
  // of the pending channel as it stood when SS_n fell.
  task automatic applyStimulus(input int nbits, input logic [31:0] mosi_word,
                               output logic [31:0] miso_word);
    logic [DW-1:0] snap;
    logic [31:0]   full;
    logic [31:0]   exp_miso;
    snap = chv[exp_chnl];
    pushChData();
    @(negedge clk);
    SS_n = 1'b0;
    if (nbits == 0) @(negedge clk);
    else repeat (4) @(negedge clk);
    miso_word = '0;
    for (int i = 0; i < nbits; i++) begin
      SCLK = 1'b0;
      MOSI = mosi_word[nbits-1-i];
      if (i == chg_bit) begin
        chv[exp_chnl] = chg_val;
        pushChData();
      end
      repeat (HALF) @(negedge clk);
      miso_word = {miso_word[30:0], MISO};
      SCLK = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    SS_n    = 1'b1;
    chg_bit = -1;
    repeat (3) @(negedge clk);
    full = {20'b0, snap};
    if (nbits <= FW) exp_miso = full >> (FW - nbits);
    else             exp_miso = full << (nbits - FW);
    if (nbits == FW) begin
      exp_cmd  = mosi_word[FW-1:0];
      exp_chnl = mosi_word[CHL +: 3];
    end
    checkOutput("miso",      miso_word,               exp_miso);
    checkOutput("rdy",       {31'b0, rdy},            {31'b0, nbits == FW});
    checkOutput("frame_err", {31'b0, frame_err},      {31'b0, nbits != FW});
    checkOutput("cmd",       {16'b0, cmd},            {16'b0, exp_cmd});
    checkOutput("chnl",      {29'b0, chnl},           {29'b0, exp_chnl});
  endtask

  initial begin
    rst_n = 1'b0;
    SS_n  = 1'b1;
    SCLK  = 1'b1;
    MOSI  = 1'b0;
    for (int i = 0; i < NCH; i++) chv[i] = '0;
    pushChData();
    exp_cmd  = '0;
    exp_chnl = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_rdy",       {31'b0, rdy},       32'd0);
    checkOutput("rst_frame_err", {31'b0, frame_err}, 32'd0);
    checkOutput("rst_cmd",       {16'b0, cmd},       32'd0);
    checkOutput("rst_chnl",      {29'b0, chnl},      32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    chv[0] = 12'hA5C;
    chv[3] = 12'h777;
    applyStimulus(16, 32'h1800, mw);
    chv[3] = 12'h123;
    applyStimulus(16, 32'h0000, mw);

    // Queue channel 5, then abort short: channel 5 must still come back.
    chv[5] = 12'h5A5;
    applyStimulus(16, 32'h2800, mw);
    applyStimulus(9, 32'h1FF, mw);
    applyStimulus(16, 32'h1000, mw);

    applyStimulus(17, 32'h1_2345, mw);
    checkOutput("miso_bit17", {31'b0, mw[0]}, 32'd0);
    applyStimulus(0, 32'h0, mw);

    chv[exp_chnl] = 12'hFFF;
    chg_bit = 6;
    chg_val = 12'h000;
    applyStimulus(16, 32'h2A55, mw);

    // Abort a frame with reset while SS_n is still low.
    @(negedge clk);
    SS_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      SCLK = 1'b0;
      MOSI = 1'($urandom_range(0, 1));
      repeat (HALF) @(negedge clk);
      SCLK = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_miso", {31'b0, MISO}, 32'd0);
    checkOutput("midrst_cmd",  {16'b0, cmd},  32'd0);
    checkOutput("midrst_chnl", {29'b0, chnl}, 32'd0);
    checkOutput("midrst_rdy",  {31'b0, rdy},  32'd0);
    @(negedge clk);
    SS_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n    = 1'b1;
    exp_cmd  = '0;
    exp_chnl = '0;
    repeat (3) @(negedge clk);
    chv[0] = 12'h9C3;
    applyStimulus(16, 32'h3800, mw);

    for (int k = 0; k < 25; k++) begin
      for (int i = 0; i < NCH; i++) chv[i] = DW'($urandom_range(0, 4095));
      applyStimulus(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : FW,
                    $urandom, mw);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
